// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM channel controller.
package pwm_pkg;
  localparam int WIDTH_DEF     = 8;
  localparam int PRE_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } state_t;
endpackage

// File: rtl/pwm_ctrl_if.sv
// Config handshake bundle between the register block and the PWM controller.
interface pwm_ctrl_if import pwm_pkg::*; #(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int PRE_WIDTH = PRE_WIDTH_DEF
) ();
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic                 cfg_pending;
  logic [WIDTH-1:0]     cfg_period;
  logic [WIDTH-1:0]     cfg_duty;
  logic [PRE_WIDTH-1:0] cfg_prescale;

  modport master (
    output cfg_valid, cfg_period, cfg_duty, cfg_prescale,
    input  cfg_ready, cfg_pending
  );

  modport slave (
    input  cfg_valid, cfg_period, cfg_duty, cfg_prescale,
    output cfg_ready, cfg_pending
  );
endinterface

// File: rtl/pwm_ctrl_prescale_tick.sv
// Prescaler: counts 0..final_value while enabled, one-clk tick at the top.
module prescale_tick #(
  parameter int PRE_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic [PRE_WIDTH-1:0] final_value,
  output logic                 tick
);
  logic [PRE_WIDTH-1:0] pcnt;

  // Tick is combinational off the count so the period counter advances in the same clk.
  assign tick = en && (pcnt == final_value);

  // Prescale counter; clr has priority so a new period always starts aligned.
  always_ff @(posedge clk) begin
    if (!rst_n)      pcnt <= '0;
    else if (clr)    pcnt <= '0;
    else if (en)     pcnt <= tick ? '0 : pcnt + 1'b1;
  end
endmodule

// File: rtl/pwm_ctrl.sv
// PWM channel controller: start/stop sequencing, boundary-aligned config updates.
module pwm_ctrl import pwm_pkg::*; #(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int PRE_WIDTH = PRE_WIDTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  pwm_ctrl_if.slave   cfg,
  output logic        pwm_out,
  output logic        period_done,
  output logic        busy
);
  state_t               state_q, state_d;
  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     per_q, per_d, duty_q, duty_d, sh_per, sh_duty;
  logic [PRE_WIDTH-1:0] pre_q, pre_d, sh_pre;
  logic                 pend_q, tick, boundary, accept, busy_d;

  assign busy            = (state_q != IDLE);
  assign cfg.cfg_ready   = !pend_q;
  assign cfg.cfg_pending = pend_q;
  assign accept          = cfg.cfg_valid && !pend_q;
  assign boundary        = busy && tick && (cnt_q == per_q);

  // Cleared throughout IDLE and whenever a new config takes over at a boundary.
  prescale_tick #(.PRE_WIDTH(PRE_WIDTH)) u_pre (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         ((state_q == IDLE) || (boundary && pend_q)),
    .en          (busy),
    .final_value (pre_q),
    .tick        (tick)
  );

  // Next-state: start beats stop in IDLE/DRAIN, stop beats start in RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (stop)  state_d = DRAIN;
      DRAIN:   if (start) state_d = RUN;
               else if (boundary) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next active config, counter and output level; pwm_out is built from next values so it has no lag.
  always_comb begin
    per_d  = per_q;
    duty_d = duty_q;
    pre_d  = pre_q;
    cnt_d  = cnt_q;
    if ((state_q == IDLE) && accept) begin
      per_d  = cfg.cfg_period;
      duty_d = cfg.cfg_duty;
      pre_d  = cfg.cfg_prescale;
    end
    if (boundary && pend_q) begin
      per_d  = sh_per;
      duty_d = sh_duty;
      pre_d  = sh_pre;
    end
    if ((state_q == IDLE) && start) cnt_d = '0;
    else if (busy && tick)          cnt_d = boundary ? '0 : cnt_q + 1'b1;
    busy_d = (state_d != IDLE);
  end

  // State, active/shadow config and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      per_q       <= '0;
      duty_q      <= '0;
      pre_q       <= '0;
      sh_per      <= '0;
      sh_duty     <= '0;
      sh_pre      <= '0;
      pend_q      <= 1'b0;
      pwm_out     <= 1'b0;
      period_done <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      per_q       <= per_d;
      duty_q      <= duty_d;
      pre_q       <= pre_d;
      pwm_out     <= busy_d && (cnt_d < duty_d);
      period_done <= boundary;
      // An accept only happens with no shadow held, so it never collides with a transfer.
      if (accept && busy) begin
        sh_per  <= cfg.cfg_period;
        sh_duty <= cfg.cfg_duty;
        sh_pre  <= cfg.cfg_prescale;
        pend_q  <= 1'b1;
      end else if (boundary) begin
        pend_q  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pwm_ctrl.sv
// Scoreboard bench for pwm_ctrl: a period-waveform reference model feeds an expectation queue.
module tb_pwm_ctrl;
  import pwm_pkg::*;
  localparam int W  = 8;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0, start = 1'b0, stop = 1'b0;
  logic pwm_out, period_done, busy;

  pwm_ctrl_if #(.WIDTH(W), .PRE_WIDTH(PW)) cif ();

  pwm_ctrl #(.WIDTH(W), .PRE_WIDTH(PW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .cfg         (cif.slave),
    .pwm_out     (pwm_out),
    .period_done (period_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit pwm;
    bit done;
    bit bsy;
    bit pend;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_no  = 0;

  // Reference model: whole-period waveform expanded at period start, consumed one clk per edge.
  bit m_busy = 0, m_drain = 0, m_pend = 0;
  int a_p = 0, a_d = 0, a_s = 0, s_p = 0, s_d = 0, s_s = 0;
  bit wave[$];

  function automatic void build();
    wave.delete();
    for (int k = 0; k <= a_p; k++)
      for (int r = 0; r <= a_s; r++)
        wave.push_back(k < a_d);
  endfunction

  function automatic void step(input bit rs, input bit st, input bit sp, input bit cv,
                               input int p, input int d, input int s);
    bit acc, bnd, was_drain, done;
    exp_t e;
    done = 0;
    if (!rs) begin
      m_busy = 0; m_drain = 0; m_pend = 0;
      a_p = 0; a_d = 0; a_s = 0; s_p = 0; s_d = 0; s_s = 0;
      wave.delete();
    end else begin
      acc = cv && !m_pend;
      if (!m_busy) begin
        if (acc) begin a_p = p; a_d = d; a_s = s; end
        if (st) begin m_busy = 1; m_drain = 0; build(); end
      end else begin
        was_drain = m_drain;
        void'(wave.pop_front());
        bnd = (wave.size() == 0);
        if (!was_drain && sp)      m_drain = 1;
        else if (was_drain && st)  m_drain = 0;
        if (bnd) begin
          done = 1;
          if (m_pend) begin a_p = s_p; a_d = s_d; a_s = s_s; m_pend = 0; end
          if (was_drain && !st) begin m_busy = 0; m_drain = 0; end
          else build();
        end
        if (acc) begin s_p = p; s_d = d; s_s = s; m_pend = 1; end
      end
    end
    e.pwm  = m_busy ? wave[0] : 1'b0;
    e.done = done;
    e.bsy  = m_busy;
    e.pend = m_pend;
    exp_q.push_back(e);
  endfunction

  // Present inputs for one clk, then record what the edge should produce.
  task automatic cyc(input bit rs, input bit st, input bit sp, input bit cv,
                     input int p, input int d, input int s);
    rst_n = rs; start = st; stop = sp;
    cif.cfg_valid    = cv;
    cif.cfg_period   = W'(p);
    cif.cfg_duty     = W'(d);
    cif.cfg_prescale = PW'(s);
    @(posedge clk);
    step(rs, st, sp, cv, p, d, s);
    cyc_no++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every clk the DUT presents a fresh output set; compare against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (pwm_out !== e.pwm || period_done !== e.done || busy !== e.bsy ||
          cif.cfg_pending !== e.pend || cif.cfg_ready !== !e.pend) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d got pwm=%b done=%b busy=%b pend=%b rdy=%b want pwm=%b done=%b busy=%b pend=%b rdy=%b",
                 cyc_no, pwm_out, period_done, busy, cif.cfg_pending, cif.cfg_ready,
                 e.pwm, e.done, e.bsy, e.pend, !e.pend);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cyc=%0d", cyc_no);
    $fatal(1, "watchdog");
  end

  initial begin
    cif.cfg_valid = 0; cif.cfg_period = '0; cif.cfg_duty = '0; cif.cfg_prescale = '0;
    // 1: basic 1,1,0,0 pattern
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 3, 2, 0);
    idle(12);
    // 2: prescale 1 doubles every level
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 3, 2, 1);
    idle(20);
    // 3: duty change mid-period lands on the next boundary
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 3, 2, 0);
    idle(1);
    cyc(1, 0, 0, 1, 3, 1, 0);
    idle(10);
    // 4: stop drains the period; start during drain continues seamlessly
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 3, 2, 0);
    idle(1);
    cyc(1, 0, 1, 0, 0, 0, 0);
    idle(6);
    cyc(1, 1, 0, 0, 0, 0, 0);
    idle(2);
    cyc(1, 0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    idle(6);
    cyc(1, 1, 1, 0, 0, 0, 0);
    idle(8);
    // 5: duty extremes
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 3, 0, 0);
    idle(9);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 3, 5, 0);
    idle(9);
    // 6: reset mid-period with a shadow pending
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 3, 2, 0);
    cyc(1, 0, 0, 1, 2, 1, 1);
    idle(1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    idle(3);
    // Random traffic
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 199) != 0, $urandom_range(0, 14) == 0, $urandom_range(0, 14) == 0,
          $urandom_range(0, 4) == 0, $urandom_range(0, 5), $urandom_range(0, 7),
          $urandom_range(0, 2));
    idle(2);
    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending expectations want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
